// File: rtl/serial_word_tx.sv
// serial_word_tx: frame controller for an LSB-first serial arithmetic unit.
//
// Accepts a parallel word (din/din_valid/din_ready). It then clears the
// downstream unit for one cycle (ser_reset) and streams WIDTH bits on ser_x
// with ser_en high. Each bit, it samples the unit's Mealy output ser_z.
// Finally it presents the assembled word on dout with a one-cycle dout_valid.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   din, din_valid    parallel operand and its offer strobe
//   din_ready         high in IDLE (and never while reset is high)
//   ser_x             serial bit to the downstream unit, LSB first
//   ser_en            downstream state-advance enable (SHIFT only)
//   ser_reset         downstream synchronous clear (CLEAR, or while reset)
//   ser_z             serial result bit from the downstream unit
//   dout, dout_valid  assembled result, held until next DONE or reset
module serial_word_tx #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_x,
  output logic             ser_en,
  output logic             ser_reset,
  input  logic             ser_z,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;   // operand, shifted right one bit per SHIFT cycle
  logic [WIDTH-1:0] rreg;   // result, filled from the MSB end
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rnext;

  // ser_z enters at the top, so after WIDTH shifts bit 0 holds the first bit.
  assign rnext = {ser_z, rreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      rreg  <= '0;
      cnt   <= '0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (din_valid) begin
          sreg <= din;
          rreg <= '0;
        end
        CLEAR: cnt <= '0;
        SHIFT: begin
          rreg <= rnext;
          sreg <= sreg >> 1;
          cnt  <= cnt + CW'(1);
          // Capture the full word on the DONE-entry edge so dout is a
          // plain register that holds until the next frame completes.
          if (cnt == CW'(WIDTH - 1)) dout <= rnext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    ser_en     = 1'b0;
    ser_reset  = 1'b0;
    ser_x      = 1'b0;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        ser_reset = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_en = 1'b1;
        ser_x  = sreg[0];
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Hold the downstream unit cleared and refuse input for the whole reset.
    if (reset) begin
      din_ready = 1'b0;
      ser_reset = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         ser_x, ser_en, ser_reset, ser_z;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         loop;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;
  exp_t q[$];

  serial_word_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_x(ser_x), .ser_en(ser_en),
    .ser_reset(ser_reset), .ser_z(ser_z), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream serial negator: copy bits up to and including the first 1,
  // invert the rest. loop=1 replaces it with a straight wire.
  logic seen = 1'b0;
  always @(posedge clk)
    if (ser_reset)   seen <= 1'b0;
    else if (ser_en) seen <= seen | ser_x;
  assign ser_z = loop ? ser_x : (ser_x ^ seen);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every dout_valid must match the oldest expectation,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_dout_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("dout", int'(dout), int'(e.data));
        chk("dout_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge in IDLE. Offers d and expects result e. It then walks
  // the frame cycle by cycle and returns at the negedge of cycle W+3.
  // keep: leave din_valid high with nd as the next word.
  // pulse: cycle in which a stray 0x11 offer is made (0 = none).
  task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] e,
                          input bit keep, input logic [W-1:0] nd, input int pulse);
    exp_t x;
    chk("din_ready_idle", int'(din_ready), 1);
    din = d;
    din_valid = 1'b1;
    x.data = e;
    x.cyc  = cyc + W + 2;
    q.push_back(x);
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k <= W + 2) begin
        chk("din_ready_busy", int'(din_ready), 0);
        chk("ser_reset", int'(ser_reset), int'(k == 1));
        chk("ser_en", int'(ser_en), int'(k >= 2 && k <= W + 1));
        if (k >= 2 && k <= W + 1) begin
          chk("ser_x", int'(ser_x), int'(d[k-2]));
          chk("ser_z", int'(ser_z), int'(e[k-2]));
        end
      end else begin
        chk("din_ready_after", int'(din_ready), 1);
      end
      if (k == 1) begin
        din_valid = keep;
        din = keep ? nd : 8'h3C;
      end
      if (pulse > 0 && k == pulse) begin
        din = 8'h11;
        din_valid = 1'b1;
      end else if (pulse > 0 && k == pulse + 1) begin
        din_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    loop = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_ser_reset", int'(ser_reset), 1);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    reset = 1'b0;
    @(negedge clk);

    run_word(8'h05, 8'hFB, 1'b0, 8'h00, 0);
    run_word(8'h00, 8'h00, 1'b0, 8'h00, 0);
    run_word(8'h80, 8'h80, 1'b0, 8'h00, 0);
    // Back-to-back with din_valid held: second word accepted in cycle 11.
    run_word(8'h01, 8'hFF, 1'b1, 8'h7F, 0);
    run_word(8'h7F, 8'h81, 1'b0, 8'h00, 0);
    loop = 1'b1;
    run_word(8'hA5, 8'hA5, 1'b0, 8'h00, 0);
    loop = 1'b0;

    // Abort a frame with reset in cycle 5 (mid-SHIFT); nothing is expected.
    din = 8'h55;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ser_reset", int'(ser_reset), 1);
    chk("abort_din_ready", int'(din_ready), 0);
    chk("abort_dout", int'(dout), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("release_din_ready", int'(din_ready), 1);
    chk("release_dout", int'(dout), 0);
    chk("release_ser_en", int'(ser_en), 0);
    run_word(8'h03, 8'hFD, 1'b0, 8'h00, 0);

    // Stray offer in cycle 4 must not disturb the in-flight word.
    run_word(8'h3C, 8'hC4, 1'b0, 8'h00, 4);

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("final_dout_hold", int'(dout), 8'hC4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
